// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI datagram controller.
//   spi_state_e         : controller FSM states
//   SPI_DATAGRAM_BITS   : default datagram width
//   SPI_DEFAULT_CLK_DIV : default SCK half-period in clk cycles
//   max4                : elaboration helper for counter sizing
package spi_pkg;

  localparam int unsigned SPI_DATAGRAM_BITS   = 40;
  localparam int unsigned SPI_DEFAULT_CLK_DIV = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_LO,
    SHIFT_HI,
    HOLD,
    GAP
  } spi_state_e;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Serializer datapath: parallel-load shift-out register plus shift-in register.
// Ports:
//   clk, rst_n      : clock, async active-low reset
//   load, load_data : capture a new transmit word (also clears receive word)
//   shift_out       : advance the transmit register one bit (MSB-first)
//   shift_in        : left-shift serial_in into the receive register LSB
//   serial_next_c   : bit that becomes current after the next shift_out
//   rx_word         : receive register contents
module spi_shift_reg #(
  parameter int unsigned SIZE = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [SIZE-1:0] load_data,
  input  logic            shift_out,
  input  logic            shift_in,
  input  logic            serial_in,
  output logic            serial_next_c,
  output logic [SIZE-1:0] rx_word
);

  logic [SIZE-1:0] tx_sr;
  logic [SIZE-1:0] rx_sr;

  // Transmit and receive shift registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sr <= '0;
      rx_sr <= '0;
    end else if (load) begin
      tx_sr <= load_data;
      rx_sr <= '0;
    end else begin
      if (shift_out) tx_sr <= {tx_sr[SIZE-2:0], 1'b0};
      if (shift_in)  rx_sr <= {rx_sr[SIZE-2:0], serial_in};
    end
  end

  // The current bit is already on MOSI, so the controller needs the one behind it
  assign serial_next_c = tx_sr[SIZE-2];
  assign rx_word       = rx_sr;

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI mode-3 datagram controller: accepts a word on valid/ready, frames it with
// chip select, drives SCK/MOSI MSB-first and returns the MISO reply word.
// Optional feature macro: SPI_LOOPBACK_EN adds loopback_in; a frame accepted
// with loopback_in=1 keeps cs_n_out high and receives its own MOSI stream.
// Ports:
//   clk_in, reset_n_in        : clock, async active-low reset
//   tx_data_in/valid/ready    : transmit word handshake (ready = IDLE)
//   rx_data_out, rx_valid_out : received word, one-cycle update pulse
//   busy_out                  : frame in progress
//   sck_out, mosi_out, miso_in, cs_n_out : SPI pins
module spi_xfer_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned SIZE     = SPI_DATAGRAM_BITS,
  parameter int unsigned CLK_DIV  = SPI_DEFAULT_CLK_DIV,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2,
  parameter int unsigned CS_IDLE  = 3
) (
  input  logic            clk_in,
  input  logic            reset_n_in,
  input  logic [SIZE-1:0] tx_data_in,
  input  logic            tx_valid_in,
  output logic            tx_ready_out,
  output logic [SIZE-1:0] rx_data_out,
  output logic            rx_valid_out,
  output logic            busy_out,
  output logic            sck_out,
  output logic            mosi_out,
  input  logic            miso_in,
`ifdef SPI_LOOPBACK_EN
  input  logic            loopback_in,
`endif
  output logic            cs_n_out
);

  localparam int unsigned CNT_MAX = max4(CLK_DIV, CS_SETUP, CS_HOLD, CS_IDLE);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned BIT_W   = $clog2(SIZE);

  if (SIZE < 2 || CLK_DIV == 0 || CS_SETUP == 0 || CS_HOLD == 0 || CS_IDLE == 0) begin : g_bad_params
    $error("spi_xfer_ctrl: parameter below its minimum");
  end

  spi_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             sck_d, mosi_d, cs_n_d, rx_valid_d, busy_d;
  logic [SIZE-1:0]  rx_data_d;
  logic             load, shift_out, shift_in;
  logic             serial_in, serial_next_c, cs_n_accept;
  logic [SIZE-1:0]  rx_word;
  int unsigned      dur;
  logic             cnt_done;

`ifdef SPI_LOOPBACK_EN
  logic lb_q;

  // Loopback mode is fixed for the whole frame at accept time
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in)                      lb_q <= 1'b0;
    else if (state_q == IDLE && tx_valid_in) lb_q <= loopback_in;
  end

  assign serial_in   = lb_q ? mosi_out : miso_in;
  assign cs_n_accept = loopback_in;
`else
  assign serial_in   = miso_in;
  assign cs_n_accept = 1'b0;
`endif

  spi_shift_reg #(.SIZE(SIZE)) u_shift (
    .clk           (clk_in),
    .rst_n         (reset_n_in),
    .load          (load),
    .load_data     (tx_data_in),
    .shift_out     (shift_out),
    .shift_in      (shift_in),
    .serial_in     (serial_in),
    .serial_next_c (serial_next_c),
    .rx_word       (rx_word)
  );

  assign tx_ready_out = (state_q == IDLE);

  // State and registered outputs
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      sck_out      <= 1'b1;
      mosi_out     <= 1'b0;
      cs_n_out     <= 1'b1;
      rx_data_out  <= '0;
      rx_valid_out <= 1'b0;
      busy_out     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      sck_out      <= sck_d;
      mosi_out     <= mosi_d;
      cs_n_out     <= cs_n_d;
      rx_data_out  <= rx_data_d;
      rx_valid_out <= rx_valid_d;
      busy_out     <= busy_d;
    end
  end

  // Next-state and output logic; every timed state uses the shared cycle counter
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    sck_d      = sck_out;
    mosi_d     = mosi_out;
    cs_n_d     = cs_n_out;
    rx_data_d  = rx_data_out;
    rx_valid_d = 1'b0;
    load       = 1'b0;
    shift_out  = 1'b0;
    shift_in   = 1'b0;
    dur        = 1;

    case (state_q)
      SETUP:             dur = CS_SETUP;
      SHIFT_LO, SHIFT_HI: dur = CLK_DIV;
      HOLD:              dur = CS_HOLD;
      GAP:               dur = CS_IDLE;
      default:           dur = 1;
    endcase
    cnt_done = (cnt_q == CNT_W'(dur - 1));
    if (state_q != IDLE) cnt_d = cnt_done ? '0 : cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (tx_valid_in) begin
          state_d = SETUP;
          load    = 1'b1;
          cs_n_d  = cs_n_accept;
          mosi_d  = tx_data_in[SIZE-1];
          bit_d   = '0;
          cnt_d   = '0;
        end
      end
      SETUP: begin
        if (cnt_done) begin
          state_d = SHIFT_LO;
          sck_d   = 1'b0;
        end
      end
      SHIFT_LO: begin
        if (cnt_done) begin
          state_d  = SHIFT_HI;
          sck_d    = 1'b1;
          shift_in = 1'b1;
        end
      end
      SHIFT_HI: begin
        if (cnt_done) begin
          if (bit_q == BIT_W'(SIZE - 1)) begin
            state_d = HOLD;
          end else begin
            state_d   = SHIFT_LO;
            sck_d     = 1'b0;
            mosi_d    = serial_next_c;
            shift_out = 1'b1;
            bit_d     = bit_q + BIT_W'(1);
          end
        end
      end
      HOLD: begin
        if (cnt_done) begin
          state_d    = GAP;
          cs_n_d     = 1'b1;
          rx_data_d  = rx_word;
          rx_valid_d = 1'b1;
          mosi_d     = 1'b0;
        end
      end
      GAP: begin
        if (cnt_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule
